// File: rtl/conv1d_requant_pool.sv
// conv1d_requant_pool: requantizes signed 32-bit conv1d accumulators to int8
// (Q31 multiply, rounding arithmetic shift, zero point, clamp, optional ReLU)
// and packs four bytes per 32-bit output word.
// Optional pair-wise max pooling is built when CONV1D_POOL_EN is defined.
module conv1d_requant_pool (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic        busy
);

    logic signed [31:0] mult_q;
    logic [4:0]         shift_q;
    logic signed [7:0]  zp_q;
    logic               relu_q;

    logic               s1_v_q, s1_last_q;
    logic signed [63:0] s1_p_q;
    logic               s2_v_q, s2_last_q;
    logic signed [63:0] s2_val_q;
    logic               s3_v_q, s3_last_q;
    logic [7:0]         s3_byte_q;

    logic [1:0]         k_q;
    logic [31:0]        word_q;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [2:0]         out_bytes_q;
    logic               out_last_q;

    logic               pk_v, pk_last, pool_busy;
    logic [7:0]         pk_byte;
    logic               complete, advance;
    logic [31:0]        pk_word;

    logic signed [63:0] in_ext, mult_ext, prod, rnd, q_next, sum, lo;
    logic [7:0]         v_next;

    // Config writes land only while the datapath is empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
        end else if (cfg_we && !busy) begin
            case (cfg_addr)
                2'd0:    mult_q  <= cfg_data;
                2'd1:    shift_q <= cfg_data[4:0];
                2'd2:    zp_q    <= cfg_data[7:0];
                default: relu_q  <= cfg_data[0];
            endcase
        end
    end

    // Arithmetic for S1 product, S2 rounding shift and S3 clamp
    always_comb begin
        in_ext   = {{32{in_data[31]}}, in_data};
        mult_ext = {{32{mult_q[31]}}, mult_q};
        prod     = in_ext * mult_ext;
        rnd      = 64'sd1 <<< ({1'b0, shift_q} + 6'd30);
        q_next   = (s1_p_q + rnd) >>> ({1'b0, shift_q} + 6'd31);
        sum      = s2_val_q + {{56{zp_q[7]}}, zp_q};
        lo       = relu_q ? {{56{zp_q[7]}}, zp_q} : -64'sd128;
        if (sum > 64'sd127)  v_next = 8'h7f;
        else if (sum < lo)   v_next = lo[7:0];
        else                 v_next = sum[7:0];
    end

    // Requantization pipeline S1..S3, all stages step together on advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_p_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            s2_val_q  <= '0;
            s3_v_q    <= 1'b0;
            s3_last_q <= 1'b0;
            s3_byte_q <= '0;
        end else if (advance) begin
            s1_v_q    <= in_valid;
            s1_last_q <= in_valid & in_last;
            s1_p_q    <= prod;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            s2_val_q  <= q_next;
            s3_v_q    <= s2_v_q;
            s3_last_q <= s2_last_q;
            s3_byte_q <= v_next;
        end
    end

`ifdef CONV1D_POOL_EN
    logic       pl_have_q, pl_v_q, pl_last_q;
    logic [7:0] pl_a_q, pl_byte_q;

    // Pair-wise signed max; a lone element carrying last passes through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pl_have_q <= 1'b0;
            pl_a_q    <= '0;
            pl_v_q    <= 1'b0;
            pl_byte_q <= '0;
            pl_last_q <= 1'b0;
        end else if (advance) begin
            pl_v_q <= 1'b0;
            if (s3_v_q) begin
                if (pl_have_q) begin
                    pl_v_q    <= 1'b1;
                    pl_byte_q <= ($signed(pl_a_q) > $signed(s3_byte_q)) ? pl_a_q : s3_byte_q;
                    pl_last_q <= s3_last_q;
                    pl_have_q <= 1'b0;
                end else if (s3_last_q) begin
                    pl_v_q    <= 1'b1;
                    pl_byte_q <= s3_byte_q;
                    pl_last_q <= 1'b1;
                end else begin
                    pl_have_q <= 1'b1;
                    pl_a_q    <= s3_byte_q;
                end
            end
        end
    end

    assign pk_v      = pl_v_q;
    assign pk_byte   = pl_byte_q;
    assign pk_last   = pl_last_q;
    assign pool_busy = pl_have_q | pl_v_q;
`else
    assign pk_v      = s3_v_q;
    assign pk_byte   = s3_byte_q;
    assign pk_last   = s3_last_q;
    assign pool_busy = 1'b0;
`endif

    assign pk_word  = word_q | ({24'd0, pk_byte} << {k_q, 3'b000});
    assign complete = pk_v && ((k_q == 2'd3) || pk_last);
    // Stall only when a finished word would overwrite an unaccepted one
    assign advance  = !out_valid_q || out_ready || !complete;

    // Packer: accumulate bytes, restart index after a completed word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q    <= '0;
            word_q <= '0;
        end else if (advance && pk_v) begin
            if (complete) begin
                k_q    <= '0;
                word_q <= '0;
            end else begin
                k_q    <= k_q + 2'd1;
                word_q <= pk_word;
            end
        end
    end

    // Output register: load on completion, else drop after a transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
        end else if (advance && complete) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pk_word;
            out_bytes_q <= {1'b0, k_q} + 3'd1;
            out_last_q  <= pk_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q | pool_busy | (k_q != 2'd0) | out_valid_q;

endmodule

// File: tb/tb_conv1d_requant_pool.sv
// Scoreboard bench for conv1d_requant_pool; honours CONV1D_POOL_EN.
module tb_conv1d_requant_pool;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        busy;

    conv1d_requant_pool dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes(out_bytes), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  n;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         m_mult, m_shift, m_zp, m_relu;
    logic [7:0] m_row[$];
    bit         m_have;
    logic [7:0] m_a;

    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

`ifdef CONV1D_POOL_EN
    localparam int NBP = 24;
`else
    localparam int NBP = 12;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] requant(input logic [31:0] x);
        longint p, q, v, lo;
        p = longint'(signed'(x)) * longint'(m_mult);
        q = (p + (longint'(1) <<< (30 + m_shift))) >>> (31 + m_shift);
        v = q + m_zp;
        lo = (m_relu != 0) ? longint'(m_zp) : -128;
        if (v > 127) v = 127;
        if (v < lo) v = lo;
        return v[7:0];
    endfunction

    function automatic void model_pack(input logic [7:0] b, input bit last);
        exp_t e;
        m_row.push_back(b);
        if (m_row.size() == 4 || last) begin
            e.d = 32'd0;
            for (int i = 0; i < m_row.size(); i++) e.d[8*i +: 8] = m_row[i];
            e.n = 3'(m_row.size());
            e.l = last;
            exp_q.push_back(e);
            m_row.delete();
        end
    endfunction

    function automatic void model_push(input logic [31:0] x, input bit last);
        logic [7:0] b;
        b = requant(x);
`ifdef CONV1D_POOL_EN
        if (!m_have && !last) begin
            m_have = 1'b1;
            m_a = b;
            return;
        end
        if (m_have) begin
            if ($signed(m_a) > $signed(b)) b = m_a;
            m_have = 1'b0;
        end
`endif
        model_pack(b, last);
    endfunction

    function automatic void model_reset();
        m_mult = 0; m_shift = 0; m_zp = 0; m_relu = 0;
        m_row.delete();
        m_have = 1'b0;
        exp_q.delete();
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [2:0] n, input logic l);
        exp_t e;
        e.d = d; e.n = n; e.l = l;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; leaves time at posedge+1
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, input bit upd);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_data = $urandom;
        if (upd) begin
            case (a)
                2'd0: m_mult = int'(d);
                2'd1: m_shift = int'(d[4:0]);
                2'd2: m_zp = int'(signed'(d[7:0]));
                default: m_relu = int'(d[0]);
            endcase
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input bit upd);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end else if (upd) begin
            model_push(d, l);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic setup(input logic [31:0] mult, input int sh, input int zp, input bit relu);
        cfg_write(2'd0, mult, 1'b1);
        cfg_write(2'd1, 32'(sh), 1'b1);
        cfg_write(2'd2, 32'(zp), 1'b1);
        cfg_write(2'd3, {31'd0, relu}, 1'b1);
    endtask

    // out_ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pop and compare on each output transfer, check stability under stall
    exp_t hold;
    bit   hold_v = 1'b0;
    always @(negedge clk) begin
        exp_t cur;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            cur.d = out_data; cur.n = out_bytes; cur.l = out_last;
            if (out_valid && hold_v) chk("stall_stable", 64'(cur), 64'(hold));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual=%h required=none", cur);
                end else begin
                    chk("out_word", 64'(cur), 64'(exp_q.pop_front()));
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold = cur;
                hold_v = 1'b1;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_bytes"}, 64'(out_bytes), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic requantize
        setup(32'h4000_0000, 0, 0, 1'b0);
        send(32'd10, 1'b0, 1'b0); send(32'd11, 1'b0, 1'b0);
        send(-32'sd3, 1'b0, 1'b0); send(32'd400, 1'b1, 1'b0);
`ifdef CONV1D_POOL_EN
        push_exp(32'h0000_7F06, 3'd2, 1'b1);
`else
        push_exp(32'h7FFF_0605, 3'd4, 1'b1);
`endif
        wait_drain();

        // Partial word, odd count
        send(32'd10, 1'b0, 1'b0); send(32'd11, 1'b0, 1'b0); send(-32'sd3, 1'b1, 1'b0);
`ifdef CONV1D_POOL_EN
        push_exp(32'h0000_FF06, 3'd2, 1'b1);
`else
        push_exp(32'h00FF_0605, 3'd3, 1'b1);
`endif
        wait_drain();

        // ReLU
        cfg_write(2'd3, 32'd1, 1'b1);
        send(32'd10, 1'b0, 1'b0); send(32'd11, 1'b0, 1'b0);
        send(-32'sd3, 1'b0, 1'b0); send(32'd400, 1'b1, 1'b0);
`ifdef CONV1D_POOL_EN
        push_exp(32'h0000_7F06, 3'd2, 1'b1);
`else
        push_exp(32'h7F00_0605, 3'd4, 1'b1);
`endif
        wait_drain();
        cfg_write(2'd3, 32'd0, 1'b1);

        // Backpressure with an ignored config write while busy
        ready_mode = 0;
        fork
            begin
                for (int i = 0; i < NBP; i++)
                    send(32'($urandom_range(0, 2000)) - 32'd1000, i == NBP - 1, 1'b1);
            end
            begin
                repeat (60) @(posedge clk);
                #1;
                cfg_write(2'd0, 32'h7FFF_FFFF, 1'b0);
                @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                ready_mode = 1;
            end
        join
        wait_drain();

        // Randomized rows under random backpressure and config
        for (int r = 0; r < 3; r++) begin
            setup($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
            ready_mode = 2;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send($urandom >> $urandom_range(0, 31), (i == 79) || ($urandom_range(0, 5) == 0),
                     1'b1);
            end
            wait_drain();
            ready_mode = 1;
        end

        // Reset mid-stream
        ready_mode = 0;
        for (int i = 0; i < 6; i++) send($urandom_range(0, 500), 1'b0, 1'b0);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        ready_mode = 1;
        @(posedge clk); #1;
        send(32'd1000, 1'b0, 1'b1); send(32'd7, 1'b1, 1'b1);  // mult is 0 after reset
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1d_requant_pool.md
CONV1D_REQUANT_POOL -- requirements
Module: conv1d_requant_pool

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  0=multiplier, 1=shift, 2=zero point, 3=flags.
- cfg_data  in  32  config write data.
- in_valid  in  1  accumulator valid, from the conv1d output buffer.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  32  signed conv1d accumulator, bias already applied.
- in_last  in  1  marks the final accumulator of a row.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  32  4 x int8; first element in byte 0.
- out_bytes  out  3  number of valid bytes, 1..4.
- out_last  out  1  word contains the row's final element.
- busy  out  1  any data held in pipeline, packer or output register.

Function
REQ-002 Config registers SHALL be as follows:
- mult: signed 32-bit, Q31.
- shift: cfg_data[4:0].
- zp: signed cfg_data[7:0].
- relu: cfg_data[0].
REQ-003 A cfg_we write SHALL take effect the next cycle only when busy=0; a write while busy=1 SHALL be ignored.
REQ-004 An input SHALL transfer on a cycle where in_valid and in_ready are both 1; an output SHALL transfer on a cycle where out_valid and out_ready are both 1.
REQ-005 S1 SHALL register the signed 64-bit product P = in_data * mult.
REQ-006 S2 SHALL register q = (P + 2^(30+shift)) >>> (31+shift), using an arithmetic shift and 64-bit intermediates.
REQ-007 S3 SHALL register v = clamp(q + zp, lo, 127), where lo = zp if relu=1, otherwise -128.
REQ-008 in_last SHALL travel with its element through S1..S3.
REQ-009 The packer SHALL append each S3 byte at byte index k = 0..3.
REQ-010 The packer SHALL move the word to the output register when k reaches 4 or when the byte carries last.
REQ-011 In the output word, unused upper bytes SHALL be 0, out_bytes SHALL equal the byte count, and out_last SHALL equal the last flag.
REQ-012 out_valid SHALL rise the cycle after the completing byte leaves S3; minimum accept-to-out_valid latency is 4 cycles.
REQ-013 Pipeline advance: S1..S3 and the packer SHALL advance together when (out_valid=0) or (out_ready=1) or (packer not completing a word this cycle); otherwise all stages SHALL hold.
REQ-014 in_ready SHALL equal the advance condition of REQ-013.
REQ-015 out_data, out_bytes and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 Simultaneous events: an output transfer and a new word completion in the same cycle SHALL load the new word without a bubble.
REQ-017 After any last element the packer index SHALL restart at 0.
REQ-018 in_data SHALL be ignored when in_valid=0.

Reset
REQ-019 Asserting reset_n=0 SHALL immediately clear all pipeline valid bits, the packer index and the output register, including mid-operation, and discard in-flight data.
REQ-020 Reset values SHALL be: in_ready 1, out_valid 0, out_data 0, out_bytes 0, out_last 0, busy 0, mult 0, shift 0, zp 0, relu 0.

Configuration
REQ-021 With the macro CONV1D_POOL_EN defined, a stage between S3 and the packer SHALL emit max(a,b) for each consecutive pair of elements; it compares signed int8 values.
REQ-022 With CONV1D_POOL_EN defined, a lone element at last SHALL pass unpaired, and pairing SHALL restart after last; each pool output adds 1 cycle of latency.
REQ-023 Without CONV1D_POOL_EN, every S3 byte SHALL go directly to the packer and no pool logic SHALL be present.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Basic requantize: mult=0x40000000, shift=0, zp=0, relu=0; inputs 10, 11, -3, 400 with last on 400 -> out_data=0x7FFF0605, out_bytes=4, out_last=1.
- ReLU: same setup with relu=1 -> out_data=0x7F000605.
- Partial word: inputs 10, 11, -3 with last on -3 -> out_data=0x00FF0605, out_bytes=3, out_last=1.
- Pooling (CONV1D_POOL_EN): inputs 10, 11, -3, 400 with last on 400 -> out_data=0x00007F06, out_bytes=2; an odd count of 3 gives 0x0000FF06.
- Backpressure: out_ready=0 while 12 inputs are offered -> in_ready falls, out_data stays stable, no bytes lost or reordered after release.
- Reset and config: reset_n pulsed mid-stream -> all outputs match REQ-020 at once; a cfg write while busy=1 does not change the result.
